lut_bist_ctrl: RTL and testbench

//  Self-test sequencer for a combinational 4-in/1-out lookup table (lut_1596 class).
//  On start, sweeps all 2**IN_W input codes into the LUT and samples y for each code.

---
 rtl/lut_bist_ctrl.sv | 123 ++++++++++++
 tb/tb_lut_bist_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_bist_ctrl.sv
// Self-test sequencer for a small combinational LUT: sweeps every input code,
// records the observed truth table and compares it against EXP_MASK.
`timescale 1ns/1ps
module lut_bist_ctrl #(
   parameter int IN_W = 4,
   parameter int SETTLE = 1,
   parameter logic [2**IN_W-1:0] EXP_MASK = 16'h0510
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [IN_W-1:0]   lut_x_o,
   input  logic              lut_y_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [2**IN_W-1:0] mask_o,
   output logic [IN_W:0]     err_cnt_o,
   output logic [IN_W-1:0]   first_err_o
);

   localparam int N     = 2**IN_W;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [IN_W-1:0]  X_LAST   = {IN_W{1'b1}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_APPLY = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]      state_reg, state_next;
   logic [IN_W-1:0] x_reg, x_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [N-1:0]    mask_reg, mask_next;
   logic [IN_W:0]   err_reg, err_next;
   logic [IN_W-1:0] first_reg, first_next;
   logic            pass_reg, pass_next;

   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      cnt_next   = cnt_reg;
      mask_next  = mask_reg;
      err_next   = err_reg;
      first_next = first_reg;
      pass_next  = pass_reg;
      case (state_reg)
         ST_IDLE: begin
            x_next   = '0;
            cnt_next = '0;
            // abort has priority over a simultaneous start
            if (start_i && !abort_i) begin
               state_next = ST_APPLY;
               mask_next  = '0;
               err_next   = '0;
               first_next = '0;
               pass_next  = 1'b0;
            end
         end
         ST_APPLY: begin
            if (abort_i) begin
               state_next = ST_IDLE;
               x_next     = '0;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               cnt_next          = '0;
               mask_next[x_reg]  = lut_y_i;
               if (lut_y_i != EXP_MASK[x_reg]) begin
                  err_next = err_reg + 1'b1;
                  if (err_reg == '0)
                     first_next = x_reg;
               end
               if (x_reg == X_LAST)
                  state_next = ST_DONE;
               else
                  x_next = x_reg + 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_DONE: begin
            pass_next  = (err_reg == '0);
            state_next = ST_IDLE;
            x_next     = '0;
         end
         default: begin
            state_next = ST_IDLE;
            x_next     = '0;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         x_reg     <= '0;
         cnt_reg   <= '0;
         mask_reg  <= '0;
         err_reg   <= '0;
         first_reg <= '0;
         pass_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         x_reg     <= x_next;
         cnt_reg   <= cnt_next;
         mask_reg  <= mask_next;
         err_reg   <= err_next;
         first_reg <= first_next;
         pass_reg  <= pass_next;
      end
   end

   assign lut_x_o     = x_reg;
   assign busy_o      = (state_reg == ST_APPLY);
   assign done_o      = (state_reg == ST_DONE);
   assign pass_o      = pass_reg;
   assign mask_o      = mask_reg;
   assign err_cnt_o   = err_reg;
   assign first_err_o = first_reg;

endmodule

// File: tb/tb_lut_bist_ctrl.sv
// Bench for lut_bist_ctrl: drives LUT truth tables into two instances
// (SETTLE=1 and SETTLE=3) and checks results against a truth-table model.
`timescale 1ns/1ps
module tb_lut_bist_ctrl;

   localparam logic [15:0] EXP = 16'h0510;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, abort;
   logic [3:0]  x, ferr;
   logic        y, busy, done, pass;
   logic [15:0] mask, tt;
   logic [4:0]  err;

   logic        s3_start, s3_abort;
   logic [3:0]  s3_x, s3_ferr;
   logic        s3_y, s3_busy, s3_done, s3_pass;
   logic [15:0] s3_mask, tt3;
   logic [4:0]  s3_err;

   int total = 0;
   int bad   = 0;

   assign y    = tt[x];
   assign s3_y = tt3[s3_x];

   lut_bist_ctrl #(.IN_W(4), .SETTLE(1), .EXP_MASK(16'h0510)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
      .lut_x_o(x), .lut_y_i(y), .busy_o(busy), .done_o(done), .pass_o(pass),
      .mask_o(mask), .err_cnt_o(err), .first_err_o(ferr)
   );

   lut_bist_ctrl #(.IN_W(4), .SETTLE(3), .EXP_MASK(16'h0510)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start_i(s3_start), .abort_i(s3_abort),
      .lut_x_o(s3_x), .lut_y_i(s3_y), .busy_o(s3_busy), .done_o(s3_done), .pass_o(s3_pass),
      .mask_o(s3_mask), .err_cnt_o(s3_err), .first_err_o(s3_ferr)
   );

   // reference model: mismatches between an observed truth table and the expected one
   function automatic int ref_err(input logic [15:0] obs);
      logic [15:0] e;
      int n;
      e = EXP;
      n = 0;
      for (int k = 0; k < 16; k++)
         if (obs[k] != e[k]) n++;
      return n;
   endfunction

   function automatic int ref_first(input logic [15:0] obs);
      logic [15:0] d;
      d = obs ^ EXP;
      for (int k = 0; k < 16; k++)
         if (d[k]) return k;
      return 0;
   endfunction

   // start a sweep from the current (negedge) cycle; returns sweep cycle of done_o, -1 on timeout
   task automatic do_sweep(output int dcyc);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dcyc = -1;
      for (int c = 1; c <= 100; c++) begin
         if (done) begin
            dcyc = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; s3_start = 1'b0; s3_abort = 1'b0;
      tt = EXP; tt3 = EXP;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
      total++; if (mask !== 16'h0) begin bad++; $display("FAIL reset_mask got=%h want=0", mask); end
      total++; if (err !== 5'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err); end
      total++; if (x !== 4'd0) begin bad++; $display("FAIL reset_x got=%0d want=0", x); end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset: outputs checked");
   endtask

   task automatic test_good_sweep();
      tt = EXP;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         total++; if (x !== 4'(c - 1)) begin bad++; $display("FAIL good_x cyc=%0d got=%0d want=%0d", c, x, c - 1); end
         total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL good_busy cyc=%0d busy=%b done=%b want busy=1 done=0", c, busy, done); end
         @(negedge clk);
      end
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL good_done17 done=%b busy=%b want done=1 busy=0", done, busy); end
      total++; if (x !== 4'd15) begin bad++; $display("FAIL good_x_done got=%0d want=15", x); end
      total++; if (pass !== 1'b0) begin bad++; $display("FAIL good_pass_in_done got=%b want=0", pass); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL good_done_pulse got=%b want=0", done); end
      total++; if (mask !== EXP) begin bad++; $display("FAIL good_mask got=%h want=%h", mask, EXP); end
      total++; if (err !== 5'd0) begin bad++; $display("FAIL good_err got=%0d want=0", err); end
      total++; if (pass !== 1'b1) begin bad++; $display("FAIL good_pass got=%b want=1", pass); end
      $display("good sweep: mask=%h err=%0d pass=%b", mask, err, pass);
   endtask

   task automatic test_faulty();
      int dc;
      tt = 16'h0118;
      do_sweep(dc);
      total++; if (dc != 17) begin bad++; $display("FAIL faulty_done_cyc got=%0d want=17", dc); end
      @(negedge clk);
      total++; if (mask !== 16'h0118) begin bad++; $display("FAIL faulty_mask got=%h want=0118", mask); end
      total++; if (err !== 5'd2) begin bad++; $display("FAIL faulty_err got=%0d want=2", err); end
      total++; if (ferr !== 4'd3) begin bad++; $display("FAIL faulty_first got=%0d want=3", ferr); end
      total++; if (pass !== 1'b0) begin bad++; $display("FAIL faulty_pass got=%b want=0", pass); end
      $display("faulty sweep: mask=%h err=%0d first=%0d pass=%b", mask, err, ferr, pass);
   endtask

   task automatic test_random();
      int dc, e;
      for (int i = 0; i < 8; i++) begin
         tt = 16'($urandom);
         if (i % 3 == 0) tt = EXP ^ (16'(i / 3) << $urandom_range(15, 0));
         e = ref_err(tt);
         do_sweep(dc);
         total++; if (dc != 17) begin bad++; $display("FAIL rand_done_cyc i=%0d got=%0d want=17", i, dc); end
         @(negedge clk);
         total++; if (mask !== tt) begin bad++; $display("FAIL rand_mask i=%0d got=%h want=%h", i, mask, tt); end
         total++; if (err !== 5'(e)) begin bad++; $display("FAIL rand_err i=%0d got=%0d want=%0d", i, err, e); end
         if (e != 0) begin
            total++; if (ferr !== 4'(ref_first(tt))) begin bad++; $display("FAIL rand_first i=%0d got=%0d want=%0d", i, ferr, ref_first(tt)); end
         end
         total++; if (pass !== (e == 0)) begin bad++; $display("FAIL rand_pass i=%0d got=%b want=%b", i, pass, e == 0); end
         $display("random sweep %0d: tt=%h err=%0d pass=%b", i, tt, err, pass);
      end
   endtask

   task automatic test_abort();
      int dc, ndone;
      tt = EXP;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
      total++; if (pass !== 1'b0) begin bad++; $display("FAIL abort_pass got=%b want=0", pass); end
      total++; if (x !== 4'd0) begin bad++; $display("FAIL abort_x got=%0d want=0", x); end
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      total++; if (ndone != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
      // simultaneous start and abort in IDLE must not launch a sweep
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_wins got=%b want=0", busy); end
      do_sweep(dc);
      total++; if (dc != 17) begin bad++; $display("FAIL abort_restart_cyc got=%0d want=17", dc); end
      @(negedge clk);
      total++; if (pass !== 1'b1 || mask !== EXP) begin bad++; $display("FAIL abort_restart pass=%b mask=%h want pass=1 mask=%h", pass, mask, EXP); end
      $display("abort: restart pass=%b", pass);
   endtask

   task automatic test_reset_mid();
      int ndone, dcyc;
      tt = EXP;
      start = 1'b1;
      @(negedge clk);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin bad++; $display("FAIL midrst_ctrl busy=%b done=%b pass=%b want 0", busy, done, pass); end
      total++; if (mask !== 16'h0 || err !== 5'd0 || ferr !== 4'd0 || x !== 4'd0) begin bad++; $display("FAIL midrst_data mask=%h err=%0d first=%0d x=%0d want 0", mask, err, ferr, x); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ndone = 0; dcyc = -1;
      for (int c = 1; c <= 17; c++) begin
         if (done) begin ndone++; dcyc = c; end
         @(negedge clk);
      end
      start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      total++; if (ndone != 1) begin bad++; $display("FAIL held_start_dones got=%0d want=1", ndone); end
      total++; if (dcyc != 17) begin bad++; $display("FAIL held_start_cyc got=%0d want=17", dcyc); end
      $display("reset mid-sweep: dones=%0d", ndone);
   endtask

   task automatic test_back_to_back();
      int dc, dc2;
      tt = EXP;
      do_sweep(dc);
      @(negedge clk);
      total++; if (pass !== 1'b1) begin bad++; $display("FAIL b2b_first_pass got=%b want=1", pass); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
      total++; if (mask !== 16'h0 || err !== 5'd0 || pass !== 1'b0) begin bad++; $display("FAIL b2b_cleared mask=%h err=%0d pass=%b want 0", mask, err, pass); end
      dc2 = -1;
      for (int c = 1; c <= 100; c++) begin
         if (done) begin dc2 = c; break; end
         @(negedge clk);
      end
      total++; if (dc2 != 17) begin bad++; $display("FAIL b2b_done_cyc got=%0d want=17", dc2); end
      @(negedge clk);
      total++; if (pass !== 1'b1 || mask !== EXP) begin bad++; $display("FAIL b2b_second pass=%b mask=%h want pass=1 mask=%h", pass, mask, EXP); end
      tt = 16'hFFFF;
      do_sweep(dc);
      @(negedge clk);
      total++; if (err !== 5'd13) begin bad++; $display("FAIL b2b_ones_err got=%0d want=13", err); end
      total++; if (ferr !== 4'd0) begin bad++; $display("FAIL b2b_ones_first got=%0d want=0", ferr); end
      total++; if (pass !== 1'b0 || mask !== 16'hFFFF) begin bad++; $display("FAIL b2b_ones pass=%b mask=%h want pass=0 mask=ffff", pass, mask); end
      $display("back-to-back: ones err=%0d first=%0d", err, ferr);
   endtask

   task automatic test_settle3();
      int dc;
      tt3 = EXP;
      s3_start = 1'b1;
      @(negedge clk);
      s3_start = 1'b0;
      dc = -1;
      for (int c = 1; c <= 80; c++) begin
         if (s3_done) begin dc = c; break; end
         total++; if (s3_x !== 4'((c - 1) / 3)) begin bad++; $display("FAIL s3_x cyc=%0d got=%0d want=%0d", c, s3_x, (c - 1) / 3); end
         @(negedge clk);
      end
      total++; if (dc != 49) begin bad++; $display("FAIL s3_done_cyc got=%0d want=49", dc); end
      @(negedge clk);
      total++; if (s3_mask !== EXP || s3_err !== 5'd0 || s3_pass !== 1'b1) begin bad++; $display("FAIL s3_result mask=%h err=%0d pass=%b want mask=%h err=0 pass=1", s3_mask, s3_err, s3_pass, EXP); end
      $display("settle3: done cycle=%0d pass=%b", dc, s3_pass);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_good_sweep();
      test_faulty();
      test_random();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_settle3();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
